// File: rtl/st_header_adder_pkg.sv
// Shared types and elaboration-time helpers for the streaming header inserter.
package st_header_adder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  // Number of output beats needed to carry one header.
  function automatic int hdr_beats(input int header_size, input int data_width);
    return header_size / data_width;
  endfunction

  // Header beat counter width; one spare bit so HDR_BEATS itself is representable.
  function automatic int hdr_cnt_width(input int header_size, input int data_width);
    return $clog2(hdr_beats(header_size, data_width)) + 1;
  endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Minimal Avalon-ST bundle: valid/ready handshake with packet delimiters.
interface avalon_st_if #(
  parameter int DATA_WIDTH = 16
) ();

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  sop;
  logic                  eop;

  modport slave  (input valid, input data, input sop, input eop, output ready);
  modport master (output valid, output data, output sop, output eop, input ready);

endinterface

// File: rtl/st_out_reg.sv
// Single-beat registered output stage. Accepts a new beat whenever it is empty
// or its current beat is being taken downstream in the same cycle.
module st_out_reg #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  ld_sop,
  input  logic                  ld_eop,
  output logic                  load,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  input  logic                  out_ready
);

  assign load = !out_valid || out_ready;

  // Hold the beat under backpressure; replace it (or go empty) when it moves on.
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the data path is reset as well; it is a handful of flops, not a
      // memory, and a known idle value on the bus eases downstream debug.
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
    end else if (load) begin
      out_valid <= ld_valid;
      if (ld_valid) begin
        out_data <= ld_data;
        out_sop  <= ld_sop;
        out_eop  <= ld_eop;
      end
    end
  end

endmodule

// File: rtl/st_header_adder.sv
// Streaming header inserter: emits a programmable header (MSB slice first)
// ahead of every input packet, then passes the payload through unchanged.
module st_header_adder
  import st_header_adder_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int HEADER_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  avalon_st_if.slave             data_in,
  input  logic [HEADER_SIZE-1:0] header_data,
  input  logic                   header_vld,
  avalon_st_if.master            data_out
);

  localparam int HDR_BEATS = hdr_beats(HEADER_SIZE, DATA_WIDTH);
  localparam int CNT_W     = hdr_cnt_width(HEADER_SIZE, DATA_WIDTH);

  if (HEADER_SIZE <= 0 || (HEADER_SIZE % DATA_WIDTH) != 0) begin : g_bad_cfg
    $error("st_header_adder: HEADER_SIZE must be a nonzero multiple of DATA_WIDTH");
  end

  state_t                 state;
  logic [HEADER_SIZE-1:0] header_reg;
  logic [HEADER_SIZE-1:0] hdr_shift;
  logic [CNT_W-1:0]       hdr_cnt;

  logic                  load;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_sop;
  logic                  ld_eop;
  logic                  in_ready;

  // Header value register; may be rewritten at any time, used at next packet start.
  always_ff @(posedge clk) begin
    if (rst) begin
      header_reg <= '0;
    end else if (header_vld) begin
      header_reg <= header_data;
    end
  end

  // Packet sequencer: snapshot the header on sop, walk its slices, then stream payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hdr_shift <= '0;
      hdr_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_in.valid && data_in.sop && load) begin
            hdr_shift <= header_reg << DATA_WIDTH;
            hdr_cnt   <= CNT_W'(1);
            state     <= (HDR_BEATS == 1) ? PAYLOAD : HEADER;
          end
        end
        HEADER: begin
          if (load) begin
            hdr_shift <= hdr_shift << DATA_WIDTH;
            hdr_cnt   <= hdr_cnt + CNT_W'(1);
            if (hdr_cnt == CNT_W'(HDR_BEATS - 1)) begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (data_in.valid && load && data_in.eop) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Select what the output register loads next and whether the input is consumed.
  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_sop   = 1'b0;
    ld_eop   = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        // Stray non-sop beats are swallowed; the sop beat waits for PAYLOAD.
        in_ready = data_in.valid && !data_in.sop;
        if (data_in.valid && data_in.sop) begin
          ld_valid = 1'b1;
          ld_data  = header_reg[HEADER_SIZE-1 -: DATA_WIDTH];
          ld_sop   = 1'b1;
        end
      end
      HEADER: begin
        ld_valid = 1'b1;
        ld_data  = hdr_shift[HEADER_SIZE-1 -: DATA_WIDTH];
      end
      PAYLOAD: begin
        in_ready = load;
        ld_valid = data_in.valid;
        ld_data  = data_in.data;
        ld_eop   = data_in.eop;
      end
      default: ;
    endcase
  end

  assign data_in.ready = in_ready;

  st_out_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_sop   (ld_sop),
    .ld_eop   (ld_eop),
    .load     (load),
    .out_valid(data_out.valid),
    .out_data (data_out.data),
    .out_sop  (data_out.sop),
    .out_eop  (data_out.eop),
    .out_ready(data_out.ready)
  );

endmodule

// File: tb/tb_st_header_adder.sv
// Bench for st_header_adder: a 16/16 and an 8/16 instance share one stimulus
// driver selected by 'sel'; expected beats come from a packet-level model.
module tb_st_header_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         = 1'b1;
  logic        sel         = 1'b0;   // 0: 16-bit instance, 1: 8-bit instance
  logic        in_valid    = 1'b0;
  logic        in_sop      = 1'b0;
  logic        in_eop      = 1'b0;
  logic [15:0] in_data     = '0;
  logic [15:0] header_data = '0;
  logic        header_vld  = 1'b0;
  logic        out_ready   = 1'b1;
  int          rdy_mode    = 0;      // 0: always ready, 1: toggle, 2: random
  int          cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  avalon_st_if #(.DATA_WIDTH(16)) i16 ();
  avalon_st_if #(.DATA_WIDTH(16)) o16 ();
  avalon_st_if #(.DATA_WIDTH(8))  i8 ();
  avalon_st_if #(.DATA_WIDTH(8))  o8 ();

  assign i16.valid = in_valid && !sel;
  assign i16.data  = in_data;
  assign i16.sop   = in_sop;
  assign i16.eop   = in_eop;
  assign o16.ready = out_ready;
  assign i8.valid  = in_valid && sel;
  assign i8.data   = in_data[7:0];
  assign i8.sop    = in_sop;
  assign i8.eop    = in_eop;
  assign o8.ready  = out_ready;

  st_header_adder #(.DATA_WIDTH(16), .HEADER_SIZE(16)) dut16 (
    .clk(clk), .rst(rst), .data_in(i16), .header_data(header_data),
    .header_vld(header_vld), .data_out(o16)
  );

  st_header_adder #(.DATA_WIDTH(8), .HEADER_SIZE(16)) dut8 (
    .clk(clk), .rst(rst), .data_in(i8), .header_data(header_data),
    .header_vld(header_vld), .data_out(o8)
  );

  logic        obs_valid, obs_sop, obs_eop, obs_ready;
  logic [15:0] obs_data;
  assign obs_valid = sel ? o8.valid : o16.valid;
  assign obs_sop   = sel ? o8.sop   : o16.sop;
  assign obs_eop   = sel ? o8.eop   : o16.eop;
  assign obs_data  = sel ? {8'h00, o8.data} : o16.data;
  assign obs_ready = sel ? i8.ready : i16.ready;

  // Reference model state: expected output beats {sop, eop, data}.
  logic [17:0] exp_q[$];
  int          acc_cyc[$];
  logic [15:0] model_hdr = '0;
  logic [15:0] pay[64];
  int          sop_cyc, sop_acc_cyc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Downstream ready pattern, updated just after each rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Output monitor: every transferred beat must match the model, and a stalled
  // beat must still be present unchanged one cycle later.
  logic        prev_stall = 1'b0;
  logic [17:0] prev_beat  = '0;
  logic [31:0] mon_exp;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("hold", {obs_valid, obs_sop, obs_eop, obs_data}, {1'b1, prev_beat});
      if (obs_valid && out_ready) begin
        mon_exp = (exp_q.size() != 0) ? {14'b0, exp_q.pop_front()} : 32'hDEAD_BEEF;
        check("out_beat", {obs_sop, obs_eop, obs_data}, mon_exp);
        acc_cyc.push_back(cyc);
      end
      prev_stall = obs_valid && !out_ready;
      prev_beat  = {obs_sop, obs_eop, obs_data};
    end
  end

  task automatic load_hdr(input logic [15:0] v);
    header_data = v;
    header_vld  = 1'b1;
    @(posedge clk);
    #1;
    header_vld  = 1'b0;
    model_hdr   = v;
  endtask

  // Present one beat and wait (bounded) for the DUT to take it.
  task automatic present(input logic [15:0] d, input logic s, input logic e,
                         input string tag, output int at);
    bit acc;
    acc      = 1'b0;
    at       = -1;
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      if (obs_ready) begin
        acc = 1'b1;
        at  = cyc;
      end
      @(posedge clk);
      #1;
      header_vld = 1'b0;
    end
    if (!acc) check(tag, 0, 1);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  // Queue the expected output for pay[0..n-1], then drive it. Beats from
  // stop_at onward are not sent; a header update is pulsed with beat hdr_at.
  task automatic send_pkt(input int n, input int stop_at, input int hdr_at,
                          input logic [15:0] new_hdr, input bit gaps);
    int          dw, hb, mask, at;
    logic [15:0] slice;
    dw   = sel ? 8 : 16;
    hb   = 16 / dw;
    mask = (1 << dw) - 1;
    for (int k = 0; k < hb; k++) begin
      slice = 16'((int'(model_hdr) >> (16 - (k + 1) * dw)) & mask);
      exp_q.push_back({k == 0, 1'b0, slice});
    end
    for (int i = 0; i < n; i++) begin
      slice = 16'(int'(pay[i]) & mask);
      exp_q.push_back({1'b0, i == n - 1, slice});
    end
    for (int i = 0; i < n; i++) begin
      if (i == stop_at) break;
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      if (i == hdr_at) begin
        header_data = new_hdr;
        header_vld  = 1'b1;
        model_hdr   = new_hdr;
      end
      if (i == 0) sop_cyc = cyc;
      present(pay[i], i == 0, i == n - 1, "in_timeout", at);
      if (i == 0) sop_acc_cyc = at;
    end
  endtask

  // A non-sop beat offered between packets must be swallowed with no output.
  task automatic send_junk();
    int at;
    present(16'($urandom), 1'b0, 1'($urandom), "junk_timeout", at);
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hdr_at;
    logic new_sel;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst16", {o16.valid, o16.sop, o16.eop, o16.data, i16.ready}, 0);
    check("rst8",  {o8.valid,  o8.sop,  o8.eop,  o8.data,  i8.ready},  0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: 16-bit, header FFFF, data 0..9, full throughput.
    sel = 1'b0;
    load_hdr(16'hFFFF);
    for (int i = 0; i < 10; i++) pay[i] = 16'(i);
    acc_cyc.delete();
    send_pkt(10, -1, -1, 16'h0, 1'b0);
    drain();
    check("t1_beats",  acc_cyc.size(), 11);
    check("t1_lat",    acc_cyc[0], sop_cyc + 1);
    check("t1_contig", acc_cyc[10], acc_cyc[0] + 10);
    check("t1_sop_acc", sop_acc_cyc, sop_cyc + 1);

    // 2: 8-bit instance, same header and data.
    sel = 1'b1;
    acc_cyc.delete();
    send_pkt(10, -1, -1, 16'h0, 1'b0);
    drain();
    check("t2_beats",  acc_cyc.size(), 12);
    check("t2_lat",    acc_cyc[0], sop_cyc + 1);
    check("t2_contig", acc_cyc[11], acc_cyc[0] + 11);
    check("t2_sop_acc", sop_acc_cyc, sop_cyc + 2);

    // 3: 8-bit, header A55A, single-beat packet.
    load_hdr(16'hA55A);
    pay[0] = 16'h003C;
    acc_cyc.delete();
    send_pkt(1, -1, -1, 16'h0, 1'b0);
    drain();
    check("t3_beats", acc_cyc.size(), 3);

    // 4: 16-bit, downstream ready toggling every cycle.
    sel      = 1'b0;
    rdy_mode = 1;
    load_hdr(16'hFFFF);
    for (int i = 0; i < 10; i++) pay[i] = 16'(i);
    acc_cyc.delete();
    send_pkt(10, -1, -1, 16'h0, 1'b0);
    drain();
    check("t4_beats", acc_cyc.size(), 11);
    rdy_mode = 0;

    // 5: header rewritten mid-payload affects only the following packet.
    send_pkt(10, -1, 5, 16'h1234, 1'b0);
    for (int i = 0; i < 3; i++) pay[i] = 16'h0100 + 16'(i);
    send_pkt(3, -1, -1, 16'h0, 1'b0);
    drain();

    // 6: reset mid-payload, then a packet with no header load.
    load_hdr(16'h5A5A);
    for (int i = 0; i < 10; i++) pay[i] = 16'h0200 + 16'(i);
    send_pkt(10, 4, -1, 16'h0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst", {o16.valid, o16.sop, o16.eop, o16.data, i16.ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    model_hdr = '0;
    for (int i = 0; i < 3; i++) pay[i] = 16'h0300 + 16'(i);
    send_pkt(3, -1, -1, 16'h0, 1'b0);
    drain();

    // Randomized traffic on both instances.
    for (int p = 0; p < 40; p++) begin
      new_sel = 1'($urandom_range(0, 1));
      if (new_sel != sel) begin
        drain();
        sel = new_sel;
      end
      rdy_mode = ($urandom_range(0, 1) != 0) ? 2 : 0;
      if ($urandom_range(0, 3) == 0) load_hdr(16'($urandom));
      if ($urandom_range(0, 3) == 0) send_junk();
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) pay[i] = 16'($urandom);
      hdr_at = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
      send_pkt(n, -1, hdr_at, 16'($urandom), 1'b1);
    end
    drain();
    check("final_q", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
